// File: rtl/fc_spike_scheduler.sv
// fc_spike_scheduler: walks a buffered spike frame into per-group weight fetches, then drains, fires and releases the buffer
module fc_spike_scheduler #(
    parameter int SYNAPSE_INDEX = 16,
    parameter int CONV1_ADDR    = 9,
    parameter int N_GROUP       = 4,
    parameter int W_ADDR        = 16,
    parameter int PE_LAT        = 2,
    localparam int GW           = N_GROUP > 1 ? $clog2(N_GROUP) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     buf_valid,
    input  logic [CONV1_ADDR:0]      buf_count,
    output logic [CONV1_ADDR-1:0]    buf_rd_addr,
    input  logic [SYNAPSE_INDEX-1:0] s_index,
    output logic                     buf_release,
    output logic                     w_rd_en,
    output logic [W_ADDR-1:0]        w_addr,
    input  logic                     pe_ready,
    output logic                     pe_acc_en,
    output logic [GW-1:0]            pe_group,
    output logic                     pe_fire,
    output logic [15:0]              frame_cnt,
    output logic                     busy
);
    localparam int AW = SYNAPSE_INDEX + 5;

    typedef enum logic [2:0] {IDLE, READ, CAPT, FETCH, DRAIN, FIRE, RELEASE, GUARD} state_t;

    state_t                   state, nxt;
    logic [CONV1_ADDR:0]      cnt;
    logic [CONV1_ADDR-1:0]    ptr;
    logic [SYNAPSE_INDEX-1:0] idx;
    logic [GW-1:0]            g;
    logic [3:0]               tcnt;
    logic [W_ADDR-1:0]        w_addr_q, wa;
    logic                     last_g, last_ptr;

    assign wa          = W_ADDR'(AW'(idx) * AW'(N_GROUP) + AW'(g));
    assign last_g      = g == GW'(N_GROUP - 1);
    assign last_ptr    = {1'b0, ptr} == cnt - (CONV1_ADDR + 1)'(1);
    assign w_addr      = w_rd_en ? wa : w_addr_q;
    assign buf_rd_addr = state == IDLE ? '0 : ptr;
    assign pe_fire     = state == FIRE;
    assign buf_release = state == RELEASE;
    assign busy        = state != IDLE;

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt     = state;
        w_rd_en = 1'b0;
        case (state)
            IDLE:    if (buf_valid) nxt = buf_count == '0 ? DRAIN : READ;
            READ:    nxt = CAPT;
            CAPT:    nxt = FETCH;
            FETCH: begin
                w_rd_en = pe_ready;
                if (pe_ready && last_g) nxt = last_ptr ? DRAIN : READ;
            end
            DRAIN:   if (tcnt == 4'(PE_LAT - 1)) nxt = FIRE;
            FIRE:    nxt = RELEASE;
            RELEASE: nxt = GUARD;
            GUARD:   if (tcnt[0]) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // tcnt restarts on every state change, so DRAIN and GUARD each see it count from 0
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt       <= '0;
            ptr       <= '0;
            idx       <= '0;
            g         <= '0;
            tcnt      <= '0;
            w_addr_q  <= '0;
            pe_acc_en <= 1'b0;
            pe_group  <= '0;
            frame_cnt <= '0;
        end else begin
            tcnt      <= nxt != state ? '0 : tcnt + 4'd1;
            pe_acc_en <= w_rd_en;
            pe_group  <= g;
            if (state == IDLE && buf_valid) begin
                cnt <= buf_count;
                ptr <= '0;
            end
            if (state == CAPT) begin
                idx <= s_index;
                g   <= '0;
            end
            if (w_rd_en) begin
                w_addr_q <= wa;
                g        <= last_g ? '0 : g + GW'(1);
                if (last_g && !last_ptr) ptr <= ptr + CONV1_ADDR'(1);
            end
            if (state == FIRE) frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_fc_spike_scheduler.sv
// tb_fc_spike_scheduler: frame-level timeline model feeds event queues; a negedge monitor matches every DUT strobe against them
module tb_fc_spike_scheduler;
    localparam int N  = 4;
    localparam int PL = 2;
    localparam int GW = 2;

    typedef struct {int cyc; int val;} ev_t;

    logic clk = 1'b0, rstn = 1'b0, buf_valid = 1'b0, pe_ready = 1'b1;
    logic [9:0] buf_count = '0;
    logic [8:0] buf_rd_addr;
    logic [15:0] s_index = '0, w_addr, frame_cnt;
    logic buf_release, w_rd_en, pe_acc_en, pe_fire, busy;
    logic [GW-1:0] pe_group;

    ev_t iss_q[$], acc_q[$], fire_q[$], rel_q[$];
    logic [15:0] mem [512];
    bit rdy [65536];
    int cyc = 0, n_cmp = 0, n_err = 0, n_rel = 0, next_idle = 0;
    logic [15:0] exp_fc = '0, last_addr = '0;
    bit prev_rst = 1'b1;

    fc_spike_scheduler #(.SYNAPSE_INDEX(16), .CONV1_ADDR(9), .N_GROUP(N), .W_ADDR(16), .PE_LAT(PL)) dut (
        .clk(clk), .rstn(rstn), .buf_valid(buf_valid), .buf_count(buf_count),
        .buf_rd_addr(buf_rd_addr), .s_index(s_index), .buf_release(buf_release),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .pe_ready(pe_ready), .pe_acc_en(pe_acc_en),
        .pe_group(pe_group), .pe_fire(pe_fire), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // buffer model: one-cycle read latency
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        s_index <= mem[buf_rd_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (prev_rst) last_addr = '0;
        prev_rst = !rstn;
        if (w_rd_en) begin
            if (iss_q.size() == 0) chk("unexpected w_rd_en", int'(w_rd_en), 0);
            else begin
                e = iss_q.pop_front();
                chk("w_rd_en cycle", cyc, e.cyc);
                chk("w_addr", int'(w_addr), e.val);
                last_addr = 16'(e.val);
            end
        end else begin
            chk("w_addr hold", int'(w_addr), int'(last_addr));
            if (iss_q.size() > 0 && iss_q[0].cyc <= cyc) begin
                chk("w_rd_en at planned cycle", int'(w_rd_en), 1);
                void'(iss_q.pop_front());
            end
        end
        if (pe_acc_en) begin
            if (acc_q.size() == 0) chk("unexpected pe_acc_en", int'(pe_acc_en), 0);
            else begin
                e = acc_q.pop_front();
                chk("pe_acc_en cycle", cyc, e.cyc);
                chk("pe_group", int'(pe_group), e.val);
            end
        end else if (acc_q.size() > 0 && acc_q[0].cyc <= cyc) begin
            chk("pe_acc_en at planned cycle", int'(pe_acc_en), 1);
            void'(acc_q.pop_front());
        end
        if (pe_fire) begin
            if (fire_q.size() == 0) chk("unexpected pe_fire", int'(pe_fire), 0);
            else begin
                e = fire_q.pop_front();
                chk("pe_fire cycle", cyc, e.cyc);
                chk("busy during fire", int'(busy), 1);
            end
        end else if (fire_q.size() > 0 && fire_q[0].cyc <= cyc) begin
            chk("pe_fire at planned cycle", int'(pe_fire), 1);
            void'(fire_q.pop_front());
        end
        if (buf_release) begin
            n_rel++;
            if (rel_q.size() == 0) chk("unexpected buf_release", int'(buf_release), 0);
            else begin
                e = rel_q.pop_front();
                chk("buf_release cycle", cyc, e.cyc);
                chk("frame_cnt at release", int'(frame_cnt), e.val);
            end
        end else if (rel_q.size() > 0 && rel_q[0].cyc <= cyc) begin
            chk("buf_release at planned cycle", int'(buf_release), 1);
            void'(rel_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        pe_ready = rdy[cyc];
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    // Timeline of one frame from the start cycle: READ, CAPT, then N issues on ready cycles per index,
    // PL drain cycles, fire, release, two guard cycles.
    task automatic plan_frame(input int n, input int pct, input int stall_at, input bit hold);
        int s, t;
        s = cyc;
        for (int k = s + 1; k < s + 40 + n * (2 + N) * 3; k++) rdy[k] = $urandom_range(99) >= pct;
        if (stall_at > 0) begin
            rdy[s + stall_at]     = 1'b0;
            rdy[s + stall_at + 1] = 1'b0;
        end
        t = s + 1;
        for (int i = 0; i < n; i++) begin
            t += 2;
            for (int gg = 0; gg < N; gg++) begin
                while (!rdy[t]) t++;
                iss_q.push_back('{t, (int'(mem[i]) * N + gg) % 65536});
                acc_q.push_back('{t + 1, gg});
                t++;
            end
        end
        t += PL;
        exp_fc++;
        fire_q.push_back('{t, 0});
        rel_q.push_back('{t + 1, int'(exp_fc)});
        next_idle = t + 4;
        buf_valid = 1'b1;
        buf_count = 10'(n);
        if (hold) return;
    endtask

    task automatic finish_frame(input bit hold);
        do begin
            step();
            buf_valid = hold || (cyc < next_idle && $urandom_range(1) == 1);
            if (!hold) buf_count = 10'($urandom);
        end while (cyc < next_idle);
    endtask

    task automatic rand_frame(input int n, input int pct);
        for (int i = 0; i < n; i++) mem[i] = 16'($urandom);
        plan_frame(n, pct, 0, 1'b0);
        finish_frame(1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " buf_rd_addr"}, int'(buf_rd_addr), 0);
        chk({tag, " buf_release"}, int'(buf_release), 0);
        chk({tag, " w_rd_en"}, int'(w_rd_en), 0);
        chk({tag, " w_addr"}, int'(w_addr), 0);
        chk({tag, " pe_acc_en"}, int'(pe_acc_en), 0);
        chk({tag, " pe_group"}, int'(pe_group), 0);
        chk({tag, " pe_fire"}, int'(pe_fire), 0);
        chk({tag, " frame_cnt"}, int'(frame_cnt), 0);
        chk({tag, " busy"}, int'(busy), 0);
    endtask

    initial begin
        int s, r0;
        for (int k = 0; k < 65536; k++) rdy[k] = 1'b1;
        for (int k = 0; k < 512; k++) mem[k] = '0;
        step();
        step();
        check_zero("reset");
        rstn = 1'b1;
        step();

        mem[0] = 16'd5; mem[1] = 16'd0; mem[2] = 16'd7;
        plan_frame(3, 0, 0, 1'b0);
        finish_frame(1'b0);

        plan_frame(0, 0, 0, 1'b0);
        finish_frame(1'b0);

        mem[0] = 16'd3;
        plan_frame(1, 0, 4, 1'b0);
        finish_frame(1'b0);

        mem[0] = 16'hFFFF;
        plan_frame(1, 0, 0, 1'b0);
        finish_frame(1'b0);

        for (int f = 0; f < 8; f++) rand_frame($urandom_range(1, 8), 30);
        rand_frame(512, 20);

        s = cyc;
        for (int i = 0; i < 3; i++) mem[i] = 16'($urandom);
        plan_frame(3, 0, 0, 1'b0);
        wait_until(s + 10);
        rstn = 1'b0;
        buf_valid = 1'b0;
        step();
        iss_q.delete(); acc_q.delete(); fire_q.delete(); rel_q.delete();
        exp_fc = '0;
        check_zero("mid-frame reset");
        rstn = 1'b1;
        step();

        r0 = n_rel;
        for (int f = 0; f < 3; f++) begin
            mem[0] = 16'($urandom); mem[1] = 16'($urandom);
            plan_frame(2, 0, 0, 1'b1);
            finish_frame(1'b1);
        end
        buf_valid = 1'b0;
        chk("held buf_valid releases", n_rel - r0, 3);
        chk("frame_cnt after 3 held frames", int'(frame_cnt), 3);
        step();

        force dut.frame_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        exp_fc = 16'hFFFF;
        plan_frame(0, 0, 0, 1'b0);
        finish_frame(1'b0);

        buf_valid = 1'b0;
        repeat (5) step();
        chk("pending w_rd_en events", iss_q.size(), 0);
        chk("pending pe_acc_en events", acc_q.size(), 0);
        chk("pending pe_fire events", fire_q.size(), 0);
        chk("pending buf_release events", rel_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
